// File: rtl/axil_to_apb_pkg.sv
// rtl/axil_to_apb_pkg.sv - shared state encoding and response codes for the AXI-Lite to APB bridge
package axil_to_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_to_apb_resp_buf.sv
// rtl/axil_to_apb_resp_buf.sv - one-entry B/R response holding register, freed by the matching ready
module axil_to_apb_resp_buf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          load_write,
    input  logic [1:0]    load_resp,
    input  logic [DW-1:0] load_data,
    input  logic          b_ready,
    input  logic          r_ready,
    output logic          b_valid,
    output logic          r_valid,
    output logic [1:0]    resp,
    output logic [DW-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            r_valid <= 1'b0;
            resp    <= 2'b00;
            data    <= '0;
        end else if (load) begin
            b_valid <= load_write;
            r_valid <= !load_write;
            resp    <= load_resp;
            data    <= load_data;
        end else if ((b_valid && b_ready) || (r_valid && r_ready)) begin
            b_valid <= 1'b0;
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axil_to_apb.sv
// rtl/axil_to_apb.sv - AXI4-Lite slave to APB master bridge; AXIL_TO_APB_ASSERT_EN enables protocol assertions
module axil_to_apb
    import axil_to_apb_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH        = 32,
    parameter int C_AXI_DATA_WIDTH        = 32,
    parameter bit OPT_OUTGOING_SKIDBUFFER = 1'b0
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    output logic [1:0]                    S_AXI_BRESP,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_APB_PADDR,
    output logic [2:0]                    M_APB_PPROT,
    output logic                          M_APB_PSEL,
    output logic                          M_APB_PENABLE,
    output logic                          M_APB_PWRITE,
    output logic [C_AXI_DATA_WIDTH-1:0]   M_APB_PWDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] M_APB_PWSTRB,
    input  logic                          M_APB_PREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   M_APB_PRDATA,
    input  logic                          M_APB_PSLVERR
);

    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam logic [AW-1:0] ADDR_MASK = ~AW'(SW - 1);

    state_t        state, state_next;
    logic          last_write;
    logic          wr_ok, rd_ok, pick_read;
    logic          can_accept, accept_rd, accept_wr;
    logic          done;
    logic          buf_b_valid, buf_r_valid;
    logic [1:0]    buf_resp;
    logic [DW-1:0] buf_data;
    logic          out_valid, out_hs;
    logic [1:0]    done_resp;
    logic [DW-1:0] done_data;

    assign wr_ok     = S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_ok     = S_AXI_ARVALID;
    // last_write high means a write was served last, so a read now has priority
    assign pick_read = rd_ok && (!wr_ok || last_write);

    assign out_valid  = buf_b_valid || buf_r_valid;
    assign out_hs     = (buf_b_valid && S_AXI_BREADY) || (buf_r_valid && S_AXI_RREADY);
    assign can_accept = S_AXI_ARESETN && (state == IDLE) && (!out_valid || out_hs);
    assign accept_rd  = can_accept && pick_read;
    assign accept_wr  = can_accept && wr_ok && !pick_read;

    assign S_AXI_ARREADY = accept_rd;
    assign S_AXI_AWREADY = accept_wr;
    assign S_AXI_WREADY  = accept_wr;

    assign M_APB_PSEL    = (state == SETUP) || (state == ACCESS);
    assign M_APB_PENABLE = (state == ACCESS);

    assign done      = (state == ACCESS) && M_APB_PREADY;
    assign done_resp = M_APB_PSLVERR ? RESP_SLVERR : RESP_OKAY;
    assign done_data = M_APB_PWRITE ? '0 : M_APB_PRDATA;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_rd || accept_wr) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (M_APB_PREADY) state_next = OPT_OUTGOING_SKIDBUFFER ? IDLE : RESP;
            RESP:    if (out_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // request fields only change on acceptance, so they hold through SETUP and ACCESS
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            last_write    <= 1'b1;
            M_APB_PADDR   <= '0;
            M_APB_PPROT   <= 3'b000;
            M_APB_PWRITE  <= 1'b0;
            M_APB_PWDATA  <= '0;
            M_APB_PWSTRB  <= '0;
        end else if (accept_rd) begin
            last_write    <= 1'b0;
            M_APB_PADDR   <= S_AXI_ARADDR & ADDR_MASK;
            M_APB_PPROT   <= S_AXI_ARPROT;
            M_APB_PWRITE  <= 1'b0;
            M_APB_PWDATA  <= '0;
            M_APB_PWSTRB  <= '0;
        end else if (accept_wr) begin
            last_write    <= 1'b1;
            M_APB_PADDR   <= S_AXI_AWADDR & ADDR_MASK;
            M_APB_PPROT   <= S_AXI_AWPROT;
            M_APB_PWRITE  <= 1'b1;
            M_APB_PWDATA  <= S_AXI_WDATA;
            M_APB_PWSTRB  <= S_AXI_WSTRB;
        end
    end

    generate
        if (OPT_OUTGOING_SKIDBUFFER) begin : g_skid
            axil_to_apb_resp_buf #(.DW(DW)) u_resp_buf (
                .clk        (S_AXI_ACLK),
                .rst_n      (S_AXI_ARESETN),
                .load       (done),
                .load_write (M_APB_PWRITE),
                .load_resp  (done_resp),
                .load_data  (done_data),
                .b_ready    (S_AXI_BREADY),
                .r_ready    (S_AXI_RREADY),
                .b_valid    (buf_b_valid),
                .r_valid    (buf_r_valid),
                .resp       (buf_resp),
                .data       (buf_data)
            );
        end else begin : g_direct
            // the FSM parks in RESP, so this register is always empty when ACCESS completes
            always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
                if (!S_AXI_ARESETN) begin
                    buf_b_valid <= 1'b0;
                    buf_r_valid <= 1'b0;
                    buf_resp    <= 2'b00;
                    buf_data    <= '0;
                end else if (done) begin
                    buf_b_valid <= M_APB_PWRITE;
                    buf_r_valid <= !M_APB_PWRITE;
                    buf_resp    <= done_resp;
                    buf_data    <= done_data;
                end else if (out_hs) begin
                    buf_b_valid <= 1'b0;
                    buf_r_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign S_AXI_BVALID = buf_b_valid;
    assign S_AXI_RVALID = buf_r_valid;
    assign S_AXI_BRESP  = buf_resp;
    assign S_AXI_RRESP  = buf_resp;
    assign S_AXI_RDATA  = buf_data;

`ifdef AXIL_TO_APB_ASSERT_EN
    a_penable_psel: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
        M_APB_PENABLE |-> M_APB_PSEL)
        else $error("axil_to_apb: PENABLE without PSEL");
    a_req_stable: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
        (state == ACCESS) |-> $stable({M_APB_PADDR, M_APB_PPROT, M_APB_PWRITE, M_APB_PWDATA, M_APB_PWSTRB}))
        else $error("axil_to_apb: APB request changed during transfer");
    a_one_valid: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
        !(S_AXI_BVALID && S_AXI_RVALID))
        else $error("axil_to_apb: BVALID and RVALID both high");
    a_b_hold: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
        (S_AXI_BVALID && !S_AXI_BREADY) |=> (S_AXI_BVALID && $stable(S_AXI_BRESP)))
        else $error("axil_to_apb: B payload not held");
    a_r_hold: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
        (S_AXI_RVALID && !S_AXI_RREADY) |=> (S_AXI_RVALID && $stable({S_AXI_RRESP, S_AXI_RDATA})))
        else $error("axil_to_apb: R payload not held");
`endif

endmodule

// File: tb/tb_axil_to_apb.sv
// tb/tb_axil_to_apb.sv - scoreboard bench for the AXI-Lite to APB bridge
module tb_axil_to_apb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awprot, arprot, pprot;
    logic [3:0]  wstrb, pwstrb;
    logic [1:0]  bresp, rresp;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    bit          seen_valid = 0;
    int          cfg_wait = 0;
    int          acc_cnt = 0;

    typedef struct {
        bit          is_write;
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } apb_t;

    rsp_t        rsp_q[$];
    apb_t        apb_q[$];
    logic [71:0] setup_vec;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign pready = penable && (acc_cnt >= cfg_wait);
    always @(posedge clk) begin
        if (penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    axil_to_apb dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .M_APB_PADDR(paddr), .M_APB_PPROT(pprot), .M_APB_PSEL(psel), .M_APB_PENABLE(penable),
        .M_APB_PWRITE(pwrite), .M_APB_PWDATA(pwdata), .M_APB_PWSTRB(pwstrb),
        .M_APB_PREADY(pready), .M_APB_PRDATA(prdata), .M_APB_PSLVERR(pslverr)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic exp_rsp(input bit w, input logic [1:0] r, input logic [31:0] d, input int lat);
        rsp_t e;
        e.is_write = w; e.resp = r; e.data = d; e.lat = lat;
        rsp_q.push_back(e);
    endtask

    task automatic exp_apb(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
        apb_t e;
        e.addr = a; e.write = w; e.wdata = d; e.strb = s; e.prot = p;
        apb_q.push_back(e);
    endtask

    // APB request monitor: SETUP contents vs expectation, ACCESS completion vs SETUP
    always @(negedge clk) begin
        if (rst_n && psel && !penable) begin
            setup_vec = {paddr, pwrite, pwdata, pwstrb, pprot};
            if (apb_q.size() == 0) timeout_fail("apb_unexpected_setup");
            else begin
                apb_t e;
                e = apb_q.pop_front();
                check("apb_req", setup_vec, {e.addr, e.write, e.wdata, e.strb, e.prot});
            end
        end
        if (rst_n && psel && penable && pready)
            check("apb_stable", {paddr, pwrite, pwdata, pwstrb, pprot}, setup_vec);
    end

    // response monitor: latency from handshake to VALID, then payload at the B/R handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if ((arvalid && arready) || (awvalid && awready)) hs_cyc = cyc;
            if ((bvalid || rvalid) && !seen_valid) begin
                seen_valid = 1;
                if (rsp_q.size() != 0) check("resp_latency", cyc - hs_cyc, rsp_q[0].lat);
            end
            if ((bvalid && bready) || (rvalid && rready)) begin
                seen_valid = 0;
                if (rsp_q.size() == 0) timeout_fail("resp_unexpected");
                else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check("resp", {bvalid, bvalid ? bresp : rresp, bvalid ? 32'h0 : rdata},
                          {e.is_write, e.resp, e.data});
                end
            end
        end else begin
            seen_valid = 0;
        end
    end

    task automatic wait_empty(input string name);
        int n = 0;
        while (rsp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0) begin
            timeout_fail(name);
            rsp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string name, input bit wr);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wr ? awready : arready) && n < 50);
        if (!(wr ? awready : arready)) timeout_fail(name);
        @(posedge clk);
        #1;
    endtask

    task automatic accept_n(input string name, input int count);
        int got = 0;
        int n = 0;
        while (got < count && n < 100) begin
            @(negedge clk);
            if (arready || awready) got++;
            n++;
        end
        if (got < count) timeout_fail(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 0; arprot = 0;
        prdata = 0; pslverr = 0;

        @(negedge clk);
        check("reset_outputs",
              {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, paddr, pprot,
               psel, penable, pwrite, pwdata, pwstrb}, 128'h0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // zero-wait write with unaligned address
        exp_apb(32'h1004, 1, 32'hDEADBEEF, 4'hF, 3'b000);
        exp_rsp(1, 2'b00, 32'h0, 3);
        awaddr = 32'h1006; wdata = 32'hDEADBEEF; wstrb = 4'hF; awprot = 3'b000;
        awvalid = 1; wvalid = 1;
        wait_accept("t1_accept", 1);
        awvalid = 0; wvalid = 0;
        wait_empty("t1_resp");

        // read with two PREADY-low cycles
        cfg_wait = 2; prdata = 32'h12345678;
        exp_apb(32'h1000, 0, 32'h0, 4'h0, 3'b010);
        exp_rsp(0, 2'b00, 32'h12345678, 5);
        araddr = 32'h1000; arprot = 3'b010; arvalid = 1;
        wait_accept("t2_accept", 0);
        arvalid = 0;
        wait_empty("t2_resp");

        // slave errors on read and on write
        cfg_wait = 0; pslverr = 1; prdata = 32'hA5A5A5A5;
        exp_apb(32'h2000, 0, 32'h0, 4'h0, 3'b001);
        exp_rsp(0, 2'b10, 32'hA5A5A5A5, 3);
        araddr = 32'h2003; arprot = 3'b001; arvalid = 1;
        wait_accept("t3r_accept", 0);
        arvalid = 0;
        wait_empty("t3r_resp");
        exp_apb(32'h2010, 1, 32'h00000042, 4'h1, 3'b100);
        exp_rsp(1, 2'b10, 32'h0, 3);
        awaddr = 32'h2010; wdata = 32'h42; wstrb = 4'h1; awprot = 3'b100;
        awvalid = 1; wvalid = 1;
        wait_accept("t3w_accept", 1);
        awvalid = 0; wvalid = 0;
        wait_empty("t3w_resp");
        pslverr = 0;

        // lone AW is never accepted; W joining releases both READYs together
        awaddr = 32'h3000; wdata = 32'h0BADF00D; wstrb = 4'h6; awprot = 3'b000;
        awvalid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lone_aw_blocked", {awready, wready, psel}, 3'b000);
        end
        exp_apb(32'h3000, 1, 32'h0BADF00D, 4'h6, 3'b000);
        exp_rsp(1, 2'b00, 32'h0, 3);
        @(posedge clk); #1;
        wvalid = 1;
        @(negedge clk);
        check("aw_w_ready_pair", {awready, wready}, 2'b11);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        wait_empty("t4_resp");

        // continuous AR and AW+W: alternate read, write, read (last served was a write)
        prdata = 32'h600DCAFE;
        exp_apb(32'h5008, 0, 32'h0, 4'h0, 3'b000);
        exp_rsp(0, 2'b00, 32'h600DCAFE, 3);
        exp_apb(32'h400C, 1, 32'hCAFEF00D, 4'h3, 3'b011);
        exp_rsp(1, 2'b00, 32'h0, 3);
        exp_apb(32'h5008, 0, 32'h0, 4'h0, 3'b000);
        exp_rsp(0, 2'b00, 32'h600DCAFE, 3);
        araddr = 32'h5008; arprot = 3'b000;
        awaddr = 32'h400E; wdata = 32'hCAFEF00D; wstrb = 4'h3; awprot = 3'b011;
        arvalid = 1; awvalid = 1; wvalid = 1;
        accept_n("t5_accepts", 3);
        arvalid = 0; awvalid = 0; wvalid = 0;
        wait_empty("t5_resp");

        // BREADY low holds B, and no new APB transfer starts behind it
        pslverr = 1; bready = 0; prdata = 32'h77778888;
        exp_apb(32'h6000, 1, 32'h00000011, 4'h1, 3'b000);
        exp_rsp(1, 2'b10, 32'h0, 3);
        exp_apb(32'h7000, 0, 32'h0, 4'h0, 3'b000);
        exp_rsp(0, 2'b10, 32'h77778888, 3);
        awaddr = 32'h6001; wdata = 32'h11; wstrb = 4'h1; awprot = 3'b000;
        araddr = 32'h7000; arprot = 3'b000;
        awvalid = 1; wvalid = 1; arvalid = 1;
        wait_accept("t6w_accept", 1);
        awvalid = 0; wvalid = 0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bvalid && n < 20);
            if (!bvalid) timeout_fail("t6_bvalid");
        end
        for (int i = 0; i < 4; i++) begin
            check("b_hold", {bvalid, bresp, psel, arready}, {1'b1, 2'b10, 1'b0, 1'b0});
            if (i < 3) @(negedge clk);
        end
        @(posedge clk); #1;
        bready = 1;
        wait_accept("t6r_accept", 0);
        arvalid = 0;
        wait_empty("t6_resp");
        pslverr = 0;

        // reset during ACCESS drops the transfer at once
        cfg_wait = 3;
        exp_apb(32'h8000, 0, 32'h0, 4'h0, 3'b000);
        araddr = 32'h8000; arvalid = 1;
        wait_accept("t7_accept", 0);
        arvalid = 0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!penable && n < 20);
            if (!penable) timeout_fail("t7_access");
        end
        rst_n = 0;
        #1;
        check("reset_mid_access", {psel, penable, bvalid, rvalid, arready, awready, paddr}, 38'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        cfg_wait = 0;
        @(posedge clk); #1;

        // after reset the arbiter favours reads even though a read was served last
        prdata = 32'h13572468;
        exp_apb(32'h9004, 0, 32'h0, 4'h0, 3'b000);
        exp_rsp(0, 2'b00, 32'h13572468, 3);
        exp_apb(32'h9008, 1, 32'h55AA55AA, 4'hC, 3'b001);
        exp_rsp(1, 2'b00, 32'h0, 3);
        araddr = 32'h9004; arprot = 3'b000;
        awaddr = 32'h9008; wdata = 32'h55AA55AA; wstrb = 4'hC; awprot = 3'b001;
        arvalid = 1; awvalid = 1; wvalid = 1;
        accept_n("t8_accepts", 2);
        arvalid = 0; awvalid = 0; wvalid = 0;
        wait_empty("t8_resp");

        repeat (3) @(posedge clk);
        check("apb_queue_drained", apb_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
